// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with a Start/Finish handshake.
// Operands are widened by one bit. Sign or zero extension then lets one datapath
// handle both signed and unsigned products.
// The multiplier takes WIDTH+1 Booth steps. Product is registered and is loaded
// only on the final step, so it never shows a partial product.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               Resetn,
  input  logic               Start,
  input  logic               Signed,
  input  logic               Abort,
  input  logic [WIDTH-1:0]   Mplier,
  input  logic [WIDTH-1:0]   Mcand,
  output logic               Busy,
  output logic               Finish,
  output logic [2*WIDTH-1:0] Product
);

  // Counter must reach WIDTH, the index of the last step.
  localparam int unsigned CntW = $clog2(WIDTH + 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  // Booth step datapath, evaluated every cycle and used only in StCalc.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] step_a;
  logic [WIDTH:0] step_q;

  function automatic logic [WIDTH:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
    return {sgn & v[WIDTH-1], v};
  endfunction

  // Add or subtract M from A, then arithmetic-shift {A,Q,Q-1} right by one.
  always_comb begin
    sum = a_q;
    case ({q_q[0], qm1_q})
      2'b10:   sum = a_q - m_q;
      2'b01:   sum = a_q + m_q;
      default: sum = a_q;
    endcase
    step_a = {sum[WIDTH], sum[WIDTH:1]};
    step_q = {sum[0], q_q[WIDTH:1]};
  end

  // Next-state logic. Abort wins over completion on the last step.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          m_d     = extend(Mcand, Signed);
          q_d     = extend(Mplier, Signed);
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (Abort) begin
          state_d = StIdle;
        end else begin
          a_d   = step_a;
          q_d   = step_q;
          qm1_d = q_q[0];
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            // The exact result fits in the low 2*WIDTH bits of {A,Q}.
            product_d = {step_a[WIDTH-2:0], step_q};
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= StIdle;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    Busy    = (state_q == StCalc);
    Finish  = (state_q == StDone);
    Product = product_q;
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and reference-model bench for booth_mult_seq at WIDTH 8, 4 and 16.
module tb_booth_mult_seq;

  logic clk;
  logic Resetn;

  logic        start8, sign8, abort8;
  logic [7:0]  mplier8, mcand8;
  logic        busy8, finish8;
  logic [15:0] product8;

  logic        start4, sign4, abort4;
  logic [3:0]  mplier4, mcand4;
  logic        busy4, finish4;
  logic [7:0]  product4;

  logic        start16, sign16, abort16;
  logic [15:0] mplier16, mcand16;
  logic        busy16, finish16;
  logic [31:0] product16;

  int tests_run;
  int tests_failed;

  booth_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .Resetn(Resetn), .Start(start8), .Signed(sign8), .Abort(abort8),
    .Mplier(mplier8), .Mcand(mcand8), .Busy(busy8), .Finish(finish8), .Product(product8)
  );

  booth_mult_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .Resetn(Resetn), .Start(start4), .Signed(sign4), .Abort(abort4),
    .Mplier(mplier4), .Mcand(mcand4), .Busy(busy4), .Finish(finish4), .Product(product4)
  );

  booth_mult_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .Resetn(Resetn), .Start(start16), .Signed(sign16), .Abort(abort16),
    .Mplier(mplier16), .Mcand(mcand16), .Busy(busy16), .Finish(finish16),
    .Product(product16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref8(input logic sg, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb, r;
    sa = sg ? {{8{a[7]}}, a} : {8'h00, a};
    sb = sg ? {{8{b[7]}}, b} : {8'h00, b};
    r  = sa * sb;
    return r;
  endfunction

  function automatic logic [7:0] ref4(input logic sg, input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] sa, sb, r;
    sa = sg ? {{4{a[3]}}, a} : {4'h0, a};
    sb = sg ? {{4{b[3]}}, b} : {4'h0, b};
    r  = sa * sb;
    return r;
  endfunction

  function automatic logic [31:0] ref16(input logic sg, input logic [15:0] a,
                                        input logic [15:0] b);
    logic signed [31:0] sa, sb, r;
    sa = sg ? {{16{a[15]}}, a} : {16'h0000, a};
    sb = sg ? {{16{b[15]}}, b} : {16'h0000, b};
    r  = sa * sb;
    return r;
  endfunction

  // One complete WIDTH=8 operation; operands are scrambled after acceptance.
  task automatic run_op8(input string name, input logic sg, input logic [7:0] mp,
                         input logic [7:0] mc, input logic [15:0] exp);
    logic [15:0] prev;
    int cyc, bc;
    bit changed;
    prev    = product8;
    sign8   = sg;
    mplier8 = mp;
    mcand8  = mc;
    start8  = 1'b1;
    tick();
    start8  = 1'b0;
    sign8   = ~sg;
    mplier8 = ~mp;
    mcand8  = mc ^ 8'h5a;
    cyc = 0;
    bc = 0;
    changed = 0;
    while (finish8 !== 1'b1 && cyc < 40) begin
      if (busy8 === 1'b1) bc++;
      if (product8 !== prev) changed = 1;
      tick();
      cyc++;
    end
    tests_run++;
    if (cyc !== 9) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d cycles, want 9", name, cyc);
    end
    tests_run++;
    if (bc !== 9) begin
      tests_failed++;
      $display("FAIL %s busy_len: got %0d, want 9", name, bc);
    end
    tests_run++;
    if (changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s product_stable: product changed before finish", name);
    end
    tests_run++;
    if (product8 !== exp) begin
      tests_failed++;
      $display("FAIL %s product: got %h, want %h", name, product8, exp);
    end
    tick();
    tests_run++;
    if (finish8 !== 1'b0 || busy8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s finish_pulse: finish=%b busy=%b, want 0 0", name, finish8, busy8);
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    start8 = 0; sign8 = 0; abort8 = 0; mplier8 = 0; mcand8 = 0;
    start4 = 0; sign4 = 0; abort4 = 0; mplier4 = 0; mcand4 = 0;
    start16 = 0; sign16 = 0; abort16 = 0; mplier16 = 0; mcand16 = 0;
    #12;
    tests_run++;
    if ({busy8, finish8, product8} !== 18'h0) begin
      tests_failed++;
      $display("FAIL reset8: busy=%b finish=%b product=%h, want 0", busy8, finish8, product8);
    end
    tests_run++;
    if ({busy4, finish4, product4, busy16, finish16, product16} !== 44'h0) begin
      tests_failed++;
      $display("FAIL reset4_16: product4=%h product16=%h, want 0", product4, product16);
    end
    #3;
    Resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    run_op8("basic_66x33", 1'b1, 8'h66, 8'h33, 16'h1452);
  endtask

  task automatic test_corners();
    run_op8("s_80x80", 1'b1, 8'h80, 8'h80, 16'h4000);
    run_op8("s_FFx7F", 1'b1, 8'hFF, 8'h7F, 16'hFF81);
    run_op8("s_FFxFF", 1'b1, 8'hFF, 8'hFF, 16'h0001);
    run_op8("u_FFxFF", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run_op8("u_00xAB", 1'b0, 8'h00, 8'hAB, 16'h0000);
    run_op8("u_FFx7F", 1'b0, 8'hFF, 8'h7F, 16'h7E81);
  endtask

  // Start held high: accepts at edges 0, 11, 22, 33; Finish after edges 9, 20, 31.
  task automatic test_back_to_back();
    int nf;
    int acc;
    logic [15:0] exp;
    nf = 0;
    sign8   = 1'b0;
    mplier8 = 8'd11;
    mcand8  = 8'd5;
    start8  = 1'b1;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (i == 10) begin
        tests_run++;
        if (busy8 !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_gap: busy=%b after done cycle, want 0", busy8);
        end
      end
      if (finish8 === 1'b1) begin
        nf++;
        acc = 11 * (nf - 1);
        exp = ref8(acc[0], 8'(acc * 37 + 11), 8'(acc * 91 + 5));
        tests_run++;
        if (i !== acc + 9) begin
          tests_failed++;
          $display("FAIL b2b_timing: finish at edge %0d, want %0d", i, acc + 9);
        end
        tests_run++;
        if (product8 !== exp) begin
          tests_failed++;
          $display("FAIL b2b_product%0d: got %h, want %h", nf, product8, exp);
        end
      end
      sign8   = 1'((i + 1) % 2);
      mplier8 = 8'((i + 1) * 37 + 11);
      mcand8  = 8'((i + 1) * 91 + 5);
    end
    start8 = 1'b0;
    tests_run++;
    if (nf !== 3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d finishes, want 3", nf);
    end
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_abort();
    int cyc;
    bit saw;
    run_op8("abort_prior", 1'b1, 8'h66, 8'h33, 16'h1452);
    sign8 = 1'b1; mplier8 = 8'h12; mcand8 = 8'h34; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    abort8 = 1'b1;
    tick();
    abort8 = 1'b0;
    tests_run++;
    if (busy8 !== 1'b0 || finish8 !== 1'b0 || product8 !== 16'h1452) begin
      tests_failed++;
      $display("FAIL abort_mid: busy=%b finish=%b product=%h, want 0 0 1452",
               busy8, finish8, product8);
    end
    saw = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (finish8 === 1'b1) saw = 1;
    end
    tests_run++;
    if (saw !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_nofinish: finish seen after abort");
    end
    // Abort on the final step edge must win over completion.
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    abort8 = 1'b1;
    tick();
    abort8 = 1'b0;
    tests_run++;
    if (busy8 !== 1'b0 || finish8 !== 1'b0 || product8 !== 16'h1452) begin
      tests_failed++;
      $display("FAIL abort_last: busy=%b finish=%b product=%h, want 0 0 1452",
               busy8, finish8, product8);
    end
    // Start and Abort together in IDLE: Start is accepted.
    sign8 = 1'b1; mplier8 = 8'h03; mcand8 = 8'h04;
    start8 = 1'b1; abort8 = 1'b1;
    tick();
    start8 = 1'b0; abort8 = 1'b0;
    tests_run++;
    if (busy8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_abort_idle: busy=%b, want 1", busy8);
    end
    cyc = 0;
    while (finish8 !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    tests_run++;
    if (finish8 !== 1'b1 || product8 !== 16'h000C) begin
      tests_failed++;
      $display("FAIL start_abort_result: finish=%b product=%h, want 1 000c", finish8, product8);
    end
    tick();
    run_op8("after_abort", 1'b1, 8'h05, 8'h07, 16'h0023);
  endtask

  task automatic test_reset_mid();
    bit saw;
    sign8 = 1'b1; mplier8 = 8'h21; mcand8 = 8'h11; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    #3;
    Resetn = 1'b0;
    #1;
    tests_run++;
    if (busy8 !== 1'b0 || finish8 !== 1'b0 || product8 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b finish=%b product=%h, want 0 0 0000",
               busy8, finish8, product8);
    end
    #2;
    Resetn = 1'b1;
    saw = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (finish8 === 1'b1) saw = 1;
    end
    tests_run++;
    if (saw !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_nofinish: finish seen after reset");
    end
    run_op8("post_reset_3x5", 1'b1, 8'h03, 8'h05, 16'h000F);
  endtask

  task automatic test_width4();
    logic [3:0] a, b;
    logic [7:0] exp;
    logic sg;
    int cyc, bc;
    for (int n = 0; n < 8; n++) begin
      a = (n == 0) ? 4'h8 : 4'($urandom);
      b = (n == 0) ? 4'h8 : 4'($urandom);
      sg = 1'(n % 2 == 0);
      exp = ref4(sg, a, b);
      sign4 = sg; mplier4 = a; mcand4 = b; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      cyc = 0; bc = 0;
      while (finish4 !== 1'b1 && cyc < 40) begin
        if (busy4 === 1'b1) bc++;
        tick();
        cyc++;
      end
      tests_run++;
      if (cyc !== 5 || bc !== 5) begin
        tests_failed++;
        $display("FAIL w4_timing%0d: latency=%0d busy=%0d, want 5 5", n, cyc, bc);
      end
      tests_run++;
      if (product4 !== exp) begin
        tests_failed++;
        $display("FAIL w4_product%0d: s=%b %h*%h got %h, want %h", n, sg, a, b, product4, exp);
      end
      tick();
    end
  endtask

  task automatic test_width16();
    logic [15:0] a, b;
    logic [31:0] exp;
    logic sg;
    int cyc, bc;
    for (int n = 0; n < 8; n++) begin
      a = (n == 1) ? 16'hFFFF : 16'($urandom);
      b = (n == 1) ? 16'hFFFF : 16'($urandom);
      sg = 1'(n % 2 == 0);
      exp = ref16(sg, a, b);
      sign16 = sg; mplier16 = a; mcand16 = b; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      cyc = 0; bc = 0;
      while (finish16 !== 1'b1 && cyc < 60) begin
        if (busy16 === 1'b1) bc++;
        tick();
        cyc++;
      end
      tests_run++;
      if (cyc !== 17 || bc !== 17) begin
        tests_failed++;
        $display("FAIL w16_timing%0d: latency=%0d busy=%0d, want 17 17", n, cyc, bc);
      end
      tests_run++;
      if (product16 !== exp) begin
        tests_failed++;
        $display("FAIL w16_product%0d: s=%b %h*%h got %h, want %h",
                 n, sg, a, b, product16, exp);
      end
      tick();
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_width4();
    test_width16();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised sequential radix-2 Booth multiplier; next generation of the lab 8-bit multControl. Adds a WIDTH parameter, a per-operation signed/unsigned mode, Busy/Abort handshake and a registered, glitch-free Product that changes only when a result completes. Sits beside the datapath as a multi-cycle arithmetic unit driven by a Start/Finish handshake.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
Resetn  input  1  asynchronous, active-low reset
Start  input  1  request; sampled only in IDLE
Signed  input  1  1 = two's-complement operands, 0 = unsigned; latched with operands
Abort  input  1  synchronous cancel of an operation in progress
Mplier  input  WIDTH  multiplier operand, latched on accepted Start
Mcand  input  WIDTH  multiplicand operand, latched on accepted Start
Busy  output  1  high while in CALC
Finish  output  1  one-cycle pulse: Product valid and newly updated
Product  output  2*WIDTH  registered result; holds last completed result

Behaviour:
- Reset (Resetn=0, async): state=IDLE; Busy=0; Finish=0; Product=0; internal A, Q, Q_-1 and counter cleared. Reset mid-operation discards the operation without a Finish pulse.
- Internal widths: M, A and Q are each WIDTH+1 bits. On load, Mcand and Mplier are extended by one bit: sign-extended if Signed=1, zero-extended if Signed=0. A=0, Q_-1=0, count=0.
- FSM states are IDLE, CALC and DONE. Outputs are Moore-style: Busy=(state==CALC), Finish=(state==DONE).
- IDLE: on an edge with Start=1, latch the operands and Signed, then go to CALC. With Start=0, stay in IDLE.
- CALC: one Booth step per edge.
  - {Q0,Q_-1}=10: A=A-M. 01: A=A+M. 00/11: no add.
  - Then arithmetic right shift of {A,Q,Q_-1} by 1. All arithmetic is modulo 2^(WIDTH+1) on A.
  - count increments each step. After exactly WIDTH+1 steps, go to DONE.
  - On the final step edge, Product is loaded with the low 2*WIDTH bits of the shifted {A,Q}.
- DONE: lasts exactly one cycle (Finish=1), then returns to IDLE unconditionally.
- Latency: Start sampled at edge k, so Finish is high in the cycle after edge k+WIDTH+1. Initiation interval with Start held high is WIDTH+3 cycles.
- Start during CALC or DONE is ignored and not queued. Operand and Signed changes after the accepted edge have no effect.
- Abort=1 on an edge in CALC: return to IDLE, no Finish, Product unchanged. Abort has priority over step completion on the final step edge. Abort in IDLE or DONE is ignored.
- Start and Abort both high in IDLE: Start is accepted.
- Product never shows partial products. It changes only on the final step edge and stays stable otherwise.
- The result is exact: the signed range fits in 2*WIDTH two's complement; the unsigned range fits in 2*WIDTH unsigned.

Test Plan:
1. WIDTH=8, Signed=1: Mplier=0x66, Mcand=0x33, Start pulsed one cycle -> Busy high 9 cycles; Finish one cycle; Product=0x1452 (5202).
2. WIDTH=8 corners: Signed=1, 0x80*0x80 -> 0x4000. Signed=1, 0xFF*0x7F -> 0xFF81. Signed=1, 0xFF*0xFF -> 0x0001. Signed=0, 0xFF*0xFF -> 0xFE01. Signed=0, 0x00*0xAB -> 0x0000.
3. Start held high with operands changing each cycle -> exactly one Finish per 11 cycles; each Product matches the operands latched at the accepting edge; Start pulses during Busy are ignored.
4. Abort asserted on the 4th CALC cycle after a prior result 0x1452 -> Busy drops next cycle; no Finish; Product stays 0x1452. A new Start then completes normally.
5. Resetn pulsed low asynchronously (mid-cycle) during CALC -> Busy, Finish and Product go to 0 immediately; no Finish follows. After release, Start 3*5 (Signed=1) -> 0x000F.
6. WIDTH=4 and WIDTH=16 instances: random signed and unsigned operands vs reference model. Latency is WIDTH+1 cycles and Busy lasts exactly WIDTH+1 cycles per operation.
